condicionador_botoes: RTL and testbench

//  Input-conditioning stage directly upstream of sinfonia_do_espectro.
//  - Synchronises and debounces the 7 note buttons and the jogar key.
//  - Drives the clean botoes[6:0] and jogar inputs of the game top level.
//  - Adds press pulses, a one-hot validity flag and an encoded note index,
//    so a bouncing or multi-pressed keyboard never produces spurious plays.

---
 rtl/condicionador_botoes.sv | 148 ++++++++++++++
 tb/tb_condicionador_botoes.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - synchroniser, debouncer and press decoder for the note buttons and jogar key
module condicionador_botoes #(
  parameter int N_BOTOES        = 7,
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int CONT_W          = 16,
  parameter bit ATIVO_BAIXO     = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_brutos,
  input  logic                jogar_bruto,
  output logic [N_BOTOES-1:0] botoes,
  output logic                jogar,
  output logic [N_BOTOES-1:0] pulso_botao,
  output logic                botao_valido,
  output logic                multiplos,
  output logic [2:0]          codigo_botao
);

  localparam int N_CANAIS = N_BOTOES + 1;

  localparam logic [1:0] SOLTO          = 2'd0;
  localparam logic [1:0] CONFIRMA_PRESS = 2'd1;
  localparam logic [1:0] PRESSIONADO    = 2'd2;
  localparam logic [1:0] CONFIRMA_SOLTA = 2'd3;

  localparam logic [CONT_W-1:0] CONT_FIM = CONT_W'(DEBOUNCE_CICLOS - 1);
  // Pressed-low pins idle high, so the chain must reset to the idle level.
  localparam logic [N_CANAIS-1:0] SYNC_RESET = ATIVO_BAIXO ? '1 : '0;

  logic [N_CANAIS-1:0] brutos;
  logic [N_CANAIS-1:0] sync1;
  logic [N_CANAIS-1:0] sync2;
  logic [N_CANAIS-1:0] estavel;
  logic [N_CANAIS-1:0] nivel_prox;

  assign brutos = {jogar_bruto, botoes_brutos};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= SYNC_RESET;
      sync2 <= SYNC_RESET;
    end else begin
      sync1 <= brutos;
      sync2 <= sync1;
    end
  end

  assign estavel = ATIVO_BAIXO ? ~sync2 : sync2;

  for (genvar c = 0; c < N_CANAIS; c++) begin : g_canal
    logic [1:0]        estado;
    logic [1:0]        estado_prox;
    logic [CONT_W-1:0] cnt;
    logic [CONT_W-1:0] cnt_prox;

    always_comb begin
      estado_prox = estado;
      cnt_prox    = cnt;
      case (estado)
        SOLTO: begin
          if (estavel[c]) begin
            estado_prox = CONFIRMA_PRESS;
            cnt_prox    = CONT_W'(1);
          end else begin
            cnt_prox = '0;
          end
        end
        CONFIRMA_PRESS: begin
          if (!estavel[c]) begin
            estado_prox = SOLTO;
            cnt_prox    = '0;
          end else if (cnt == CONT_FIM) begin
            estado_prox = PRESSIONADO;
            cnt_prox    = '0;
          end else begin
            cnt_prox = cnt + CONT_W'(1);
          end
        end
        PRESSIONADO: begin
          if (!estavel[c]) begin
            estado_prox = CONFIRMA_SOLTA;
            cnt_prox    = CONT_W'(1);
          end else begin
            cnt_prox = '0;
          end
        end
        default: begin
          if (estavel[c]) begin
            estado_prox = PRESSIONADO;
            cnt_prox    = '0;
          end else if (cnt == CONT_FIM) begin
            estado_prox = SOLTO;
            cnt_prox    = '0;
          end else begin
            cnt_prox = cnt + CONT_W'(1);
          end
        end
      endcase
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        estado <= SOLTO;
        cnt    <= '0;
      end else begin
        estado <= estado_prox;
        cnt    <= cnt_prox;
      end
    end

    // Outputs are registered from the next state so every flag moves on the acceptance edge.
    assign nivel_prox[c] = (estado_prox == PRESSIONADO) || (estado_prox == CONFIRMA_SOLTA);
  end

  logic [N_BOTOES-1:0] botoes_prox;
  logic [N_BOTOES-1:0] sem_menor;
  logic [2:0]          codigo_prox;

  assign botoes_prox = nivel_prox[N_BOTOES-1:0];
  assign sem_menor   = botoes_prox & (botoes_prox - N_BOTOES'(1));

  always_comb begin
    codigo_prox = 3'd0;
    for (int i = N_BOTOES - 1; i >= 0; i--) begin
      if (botoes_prox[i]) codigo_prox = 3'(i + 1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes       <= '0;
      jogar        <= 1'b0;
      pulso_botao  <= '0;
      botao_valido <= 1'b0;
      multiplos    <= 1'b0;
      codigo_botao <= 3'd0;
    end else begin
      botoes       <= botoes_prox;
      jogar        <= nivel_prox[N_BOTOES];
      pulso_botao  <= botoes_prox & ~botoes;
      botao_valido <= (botoes_prox != '0) && (sem_menor == '0);
      multiplos    <= sem_menor != '0;
      codigo_botao <= codigo_prox;
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - bench for condicionador_botoes
module tb_condicionador_botoes;

  localparam int NB = 7;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] botoes_brutos = '0;
  logic          jogar_bruto = 1'b0;
  logic [NB-1:0] botoes;
  logic          jogar;
  logic [NB-1:0] pulso_botao;
  logic          botao_valido;
  logic          multiplos;
  logic [2:0]    codigo_botao;

  logic [NB-1:0] ab_brutos = '1;
  logic          ab_jogar_bruto = 1'b1;
  logic [NB-1:0] ab_botoes;
  logic          ab_jogar;
  logic [NB-1:0] ab_pulso;
  logic          ab_valido;
  logic          ab_multiplos;
  logic [2:0]    ab_codigo;

  always #5 clock = ~clock;

  condicionador_botoes #(.N_BOTOES(NB), .DEBOUNCE_CICLOS(D), .CONT_W(16), .ATIVO_BAIXO(1'b0)) dut (
    .clock(clock), .reset(reset), .botoes_brutos(botoes_brutos), .jogar_bruto(jogar_bruto),
    .botoes(botoes), .jogar(jogar), .pulso_botao(pulso_botao), .botao_valido(botao_valido),
    .multiplos(multiplos), .codigo_botao(codigo_botao));

  condicionador_botoes #(.N_BOTOES(NB), .DEBOUNCE_CICLOS(D), .CONT_W(16), .ATIVO_BAIXO(1'b1)) dut_ab (
    .clock(clock), .reset(reset), .botoes_brutos(ab_brutos), .jogar_bruto(ab_jogar_bruto),
    .botoes(ab_botoes), .jogar(ab_jogar), .pulso_botao(ab_pulso), .botao_valido(ab_valido),
    .multiplos(ab_multiplos), .codigo_botao(ab_codigo));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic espera(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference: a channel flips once its raw level, seen two cycles late, has disagreed
  // with the debounced level for D consecutive samples.
  logic [NB:0]   hist[$];
  logic [NB:0]   m_nivel = '0;
  logic [NB-1:0] m_pulso = '0;
  logic          m_valido = 1'b0;
  logic          m_mult = 1'b0;
  logic [2:0]    m_codigo = 3'd0;
  logic          chk_en = 1'b0;

  always @(posedge clock) begin : modelo
    logic [NB:0] novo;
    logic        difere;
    int          n;
    logic [2:0]  cod;
    if (!reset) begin
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back('0);
      m_nivel  <= '0;
      m_pulso  <= '0;
      m_valido <= 1'b0;
      m_mult   <= 1'b0;
      m_codigo <= 3'd0;
    end else begin
      hist.push_back({jogar_bruto, botoes_brutos});
      void'(hist.pop_front());
      novo = m_nivel;
      for (int c = 0; c <= NB; c++) begin
        difere = 1'b1;
        for (int k = 0; k < D; k++) if (hist[k][c] == m_nivel[c]) difere = 1'b0;
        if (difere) novo[c] = ~m_nivel[c];
      end
      n = $countones(novo[NB-1:0]);
      cod = 3'd0;
      for (int i = NB - 1; i >= 0; i--) if (novo[i]) cod = 3'(i + 1);
      m_nivel  <= novo;
      m_pulso  <= novo[NB-1:0] & ~m_nivel[NB-1:0];
      m_valido <= (n == 1);
      m_mult   <= (n >= 2);
      m_codigo <= cod;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("modelo_botoes", 32'(botoes), 32'(m_nivel[NB-1:0]));
      check("modelo_jogar", 32'(jogar), 32'(m_nivel[NB]));
      check("modelo_pulso", 32'(pulso_botao), 32'(m_pulso));
      check("modelo_valido", 32'(botao_valido), 32'(m_valido));
      check("modelo_multiplos", 32'(multiplos), 32'(m_mult));
      check("modelo_codigo", 32'(codigo_botao), 32'(m_codigo));
    end
  end

  logic ab_mon = 1'b1;
  logic ab_ruim = 1'b0;
  always @(negedge clock) begin
    if (ab_mon && ((ab_botoes != '0) || (ab_pulso != '0) || ab_jogar || ab_valido || (ab_codigo != 3'd0)))
      ab_ruim <= 1'b1;
  end

  typedef struct {
    logic [NB-1:0] brutos;
    logic          jogar_b;
    logic [NB-1:0] botoes_e;
    logic [2:0]    codigo_e;
    logic          valido_e;
    logic          mult_e;
  } vetor_t;

  vetor_t tabela[7];

  initial begin
    int pulsos;
    int ruins;

    tabela[0] = '{7'b0000100, 1'b0, 7'b0000100, 3'd3, 1'b1, 1'b0};
    tabela[1] = '{7'b0100010, 1'b1, 7'b0100010, 3'd2, 1'b0, 1'b1};
    tabela[2] = '{7'b1000000, 1'b1, 7'b1000000, 3'd7, 1'b1, 1'b0};
    tabela[3] = '{7'b0000001, 1'b0, 7'b0000001, 3'd1, 1'b1, 1'b0};
    tabela[4] = '{7'b1111111, 1'b1, 7'b1111111, 3'd1, 1'b0, 1'b1};
    tabela[5] = '{7'b1110000, 1'b0, 7'b1110000, 3'd5, 1'b0, 1'b1};
    tabela[6] = '{7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0};

    espera(3);
    reset = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("repouso", {20'd0, botoes, pulso_botao, codigo_botao, botao_valido, multiplos, jogar},
            32'd0);
    end

    botoes_brutos = 7'b0000100;
    espera(5);
    check("press_antes", 32'(botoes), 32'd0);
    espera(1);
    check("press_botoes", 32'(botoes), 32'h04);
    check("press_pulso", 32'(pulso_botao), 32'h04);
    check("press_codigo", 32'(codigo_botao), 32'd3);
    check("press_valido", 32'(botao_valido), 32'd1);
    espera(1);
    check("press_pulso_unico", 32'(pulso_botao), 32'd0);
    botoes_brutos = '0;
    espera(8);

    pulsos = 0;
    for (int i = 0; i < 18; i++) begin
      botoes_brutos[0] = (i < 8) ? ((i % 4) < 2) : 1'b1;
      @(negedge clock);
      if (pulso_botao[0]) pulsos++;
      if (i == 12) check("ressalto_antes", 32'(botoes[0]), 32'd0);
      if (i == 13) check("ressalto_aceito", 32'(botoes[0]), 32'd1);
    end
    check("ressalto_pulsos", 32'(pulsos), 32'd1);
    botoes_brutos = '0;
    espera(8);

    botoes_brutos = 7'b0100010;
    espera(6);
    check("multi_botoes", 32'(botoes), 32'h22);
    check("multi_pulso", 32'(pulso_botao), 32'h22);
    check("multi_multiplos", 32'(multiplos), 32'd1);
    check("multi_valido", 32'(botao_valido), 32'd0);
    check("multi_codigo", 32'(codigo_botao), 32'd2);
    botoes_brutos = '0;
    espera(8);

    botoes_brutos = 7'b0001000;
    espera(8);
    ruins = 0;
    for (int i = 0; i < 12; i++) begin
      botoes_brutos[3] = (i >= 2);
      @(negedge clock);
      if (!botoes[3] || (pulso_botao != '0)) ruins++;
    end
    check("glitch_soltura", 32'(ruins), 32'd0);
    botoes_brutos = '0;
    espera(8);

    botoes_brutos = 7'b1000000;
    espera(8);
    check("reset_pre", 32'(botoes), 32'h40);
    botoes_brutos = 7'b1010000;
    espera(3);
    reset = 1'b0;
    #1;
    check("reset_limpa", {22'd0, botoes, codigo_botao}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    espera(5);
    check("reset_janela", 32'(botoes), 32'd0);
    espera(1);
    check("reset_aceito", 32'(botoes), 32'h50);
    check("reset_pulso", 32'(pulso_botao), 32'h50);
    check("reset_codigo", 32'(codigo_botao), 32'd5);
    botoes_brutos = '0;
    espera(8);

    foreach (tabela[v]) begin
      botoes_brutos = tabela[v].brutos;
      jogar_bruto   = tabela[v].jogar_b;
      espera(8);
      check("tab_botoes", 32'(botoes), 32'(tabela[v].botoes_e));
      check("tab_jogar", 32'(jogar), 32'(tabela[v].jogar_b));
      check("tab_codigo", 32'(codigo_botao), 32'(tabela[v].codigo_e));
      check("tab_valido", 32'(botao_valido), 32'(tabela[v].valido_e));
      check("tab_multiplos", 32'(multiplos), 32'(tabela[v].mult_e));
      check("tab_pulso", 32'(pulso_botao), 32'd0);
    end

    for (int t = 0; t < 3000; t++) begin
      @(negedge clock);
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 5) == 0) botoes_brutos[b] = ~botoes_brutos[b];
      if ($urandom_range(0, 5) == 0) jogar_bruto = ~jogar_bruto;
      if (t == 1500) reset = 1'b0;
      if (t == 1501) reset = 1'b1;
    end
    botoes_brutos = '0;
    jogar_bruto = 1'b0;
    espera(8);

    check("ativo_baixo_quieto", 32'(ab_ruim), 32'd0);
    ab_mon = 1'b0;
    ab_brutos = 7'b1110111;
    espera(5);
    check("ativo_baixo_antes", 32'(ab_botoes), 32'd0);
    espera(1);
    check("ativo_baixo_press", 32'(ab_botoes), 32'h08);
    check("ativo_baixo_pulso", 32'(ab_pulso), 32'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
